ramz_reader: RTL and testbench
==============================

# ramz_reader

Burst read engine for the read-only port B of the 128 x 32 `ramz` dual-port RAM. A command (start address, length) starts the burst. The engine issues sequential port-B reads, absorbs the RAM's one-cycle synchronous read latency, and presents the words as a valid/ready stream with a last-beat marker. It is the consumer-side counterpart to the port-A writer. It lets downstream logic drain a buffer the producer has filled, at one word per cycle under full backpressure.

## Interface
- `ADDR_W`, 7, RAM address width (128 words)
- `DATA_W`, 32, RAM and stream data width
- `LEN_W`, 8, burst length width (0..128 used)
- `clk`  in  1  single clock; the same clock drives `ramz` clkb
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  command strobe; sampled only when `busy`=0
- `start_addr`  in  ADDR_W  first word address
- `len`  in  LEN_W  number of words; values >128 are clamped to 128
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse at burst completion
- `ram_addr`  out  ADDR_W  registered address to `ramz` addrb
- `ram_dout`  in  DATA_W  `ramz` doutb; valid the cycle after `ram_addr` is held across an edge
- `m_data`  out  DATA_W  stream data
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready
- `m_last`  out  1  high with the final beat of the burst

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 with `len`≠0 latches the address and remaining count (clamped), sets `busy`, and goes to RUN.
  - `start`=1 with `len`=0 pulses `done` the next cycle, never asserts `busy`, and stays in IDLE.
- RUN: issues one read per cycle while occupancy + in-flight reads < 4. Occupancy is the entries in the 4-entry output buffer; in-flight is reads issued but not yet captured (max 2). The address increments modulo 128 (127→0 wraps). After the last read is issued, go to DRAIN.
- DRAIN: no reads issued. When the last-tagged beat handshakes (`m_valid`&`m_ready`), go to IDLE.
- Data capture: the word is taken from `ram_dout` exactly 2 cycles after the issue decision and pushed into the buffer together with its last tag.
- Output: the buffer head drives `m_data`/`m_last`. `m_valid` = buffer non-empty. `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- Completion: `done` pulses the cycle after the last-beat handshake. `busy` falls in that same cycle.
- `start` while `busy`=1 is ignored.
- Simultaneous push and pop on the buffer is legal. Occupancy is unchanged in that case.
- The engine never writes the RAM. Port A may be written concurrently. A word written at the address being read in the same cycle returns old data, which is the RAM's no-writethrough behaviour.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `ram_addr`=0. State IDLE, buffer empty, no reads in flight.
- Command sampled in cycle 0. `ram_addr`=start_addr in cycle 1, `ram_dout` valid in cycle 2, first `m_valid`=1 in cycle 3.
- With `m_ready` held 1: one beat per cycle, so an N-word burst has its last beat in cycle N+2 and `done` in cycle N+3.
- Backpressure: reads stop issuing within 1 cycle of the buffer-plus-in-flight limit. The buffer never overflows and no word is lost or duplicated.
- `rst` mid-burst, at the next edge:
  - the burst is aborted;
  - the buffer is flushed and in-flight reads are discarded;
  - all outputs take their reset values;
  - no `done` pulse is produced.

## Test plan
- RAM preloaded with word i = 0xA500_0000+i. start_addr=0x10, len=8, `m_ready`=1 -> beats 0xA500_0010..0xA500_0017 in cycles 3..10, `m_last` only on cycle 10, `done` in cycle 11.
- start_addr=126, len=4 -> `ram_addr` sequence 126, 127, 0, 1; data returned in that order, last on the 4th beat.
- len=16 with `m_ready` toggling pseudo-randomly (including 5-cycle stalls) -> all 16 words in order with no loss or duplication. `m_data` holds during stalls. Occupancy + in-flight never exceeds 4.
- len=0 -> `done` the next cycle, `busy` never high, no `m_valid`. A second `start` asserted while a len=5 burst is busy -> ignored, exactly 5 beats.
- len=200 -> clamped to 128 beats, and the address wraps back to start_addr.
- `rst` asserted on the 3rd beat of a len=10 burst -> the next cycle all outputs are 0, no `done`. A new start_addr=0, len=2 burst then completes normally.

Source files
------------

// File: rtl/ramz_reader.sv
// ramz_reader: burst read engine for ramz port B.
// Sequential reads, 2-deep latency pipe, 4-entry stream buffer.
module ramz_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  state_t            state;
  logic [LEN_W-1:0]  rem;
  logic              v1;
  logic              t1;
  logic              v2;
  logic              t2;
  logic [DATA_W-1:0] buf_data [4];
  logic              buf_last [4];
  logic [1:0]        rd_ptr;
  logic [1:0]        wr_ptr;
  logic [2:0]        occ;

  logic [LEN_W-1:0]  len_c;
  logic [2:0]        total;
  logic              room;
  logic              push;
  logic              pop;

  // v1: address on ram_addr is a live read; v2: ram_dout is live
  assign push    = v2;
  assign m_valid = (occ != 3'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = buf_data[rd_ptr];
  assign m_last  = m_valid & buf_last[rd_ptr];
  assign len_c   = (len > MAX_LEN) ? MAX_LEN : len;
  assign total   = occ + {2'b0, v1} + {2'b0, v2};
  assign room    = (total < 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_addr <= '0;
      v1       <= 1'b0;
      t1       <= 1'b0;
      v2       <= 1'b0;
      t2       <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      v1   <= 1'b0;
      t1   <= 1'b0;
      v2   <= v1;
      t2   <= t1;
      if (push) begin
        buf_data[wr_ptr] <= ram_dout;
        buf_last[wr_ptr] <= t2;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      occ <= occ + {2'b0, push} - {2'b0, pop};
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              ram_addr <= start_addr;
              v1       <= 1'b1;
              t1       <= (len_c == LEN_W'(1));
              rem      <= len_c - LEN_W'(1);
              busy     <= 1'b1;
              state    <= (len_c == LEN_W'(1)) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (room) begin
            ram_addr <= ram_addr + ADDR_W'(1);
            v1       <= 1'b1;
            t1       <= (rem == LEN_W'(1));
            rem      <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramz_reader.sv
// tb_ramz_reader: random bursts vs a queue-free index model.
// RAM port B modelled as a 1-cycle synchronous read.
module tb_ramz_reader;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  logic [DATA_W-1:0] mem [128];

  int checks   = 0;
  int failures = 0;

  ramz_reader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready held 1, 1: coin flip, 2: coin flip plus 5-cycle stalls
  task automatic run_burst(input int a, input int n, input int mode,
                           input bit timing, input int ign);
    int nb;
    int cyc;
    int beats;
    int last_cyc;
    int stall_left;
    bit stalled;
    bit fin;
    logic [DATA_W-1:0] held;
    nb = (n > 128) ? 128 : n;
    start      = 1'b1;
    start_addr = ADDR_W'(a);
    len        = LEN_W'(n);
    @(posedge clk);
    #1;
    start      = 1'b0;
    cyc        = 1;
    beats      = 0;
    last_cyc   = -1;
    stall_left = 0;
    stalled    = 1'b0;
    fin        = 1'b0;
    held       = '0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (mode == 0) begin
        m_ready = 1'b1;
      end else if (mode == 2 && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (mode == 2 && $urandom_range(0, 5) == 0) begin
        m_ready    = 1'b0;
        stall_left = 4;
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      if (ign != 0 && cyc == ign) begin
        start      = 1'b1;
        start_addr = ADDR_W'($urandom);
        len        = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (m_valid && stalled) chk("hold", m_data, held);
      if (m_valid && m_ready) begin
        chk("data", m_data, mem[(a + beats) % 128]);
        chk("last", m_last, (beats == nb - 1));
        if (timing) chk("beat_cyc", cyc, beats + 3);
        beats++;
        last_cyc = cyc;
        stalled  = 1'b0;
      end else begin
        stalled = m_valid;
        held    = m_data;
      end
      if (done) begin
        chk("done_beats", beats, nb);
        chk("done_cyc", cyc, last_cyc + 1);
        chk("busy_at_done", busy, 0);
        if (timing) chk("done_n3", cyc, nb + 3);
        fin = 1'b1;
      end else begin
        chk("busy", busy, 1);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + i;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    m_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_addr", ram_addr, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_burst(16, 8, 0, 1'b1, 0);
    run_burst(126, 4, 0, 1'b1, 0);
    run_burst(40, 16, 2, 1'b0, 0);
    run_burst(3, 5, 1, 1'b0, 2);

    start = 1'b1;
    len   = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_valid", m_valid, 0);
    @(negedge clk);
    chk("len0_done2", done, 0);
    chk("len0_busy2", busy, 0);
    @(posedge clk);
    #1;

    run_burst(70, 200, 0, 1'b1, 0);

    for (int r = 0; r < 8; r++) begin
      run_burst(int'($urandom_range(0, 127)), int'($urandom_range(1, 40)),
                int'($urandom_range(1, 2)), 1'b0, 0);
    end

    start      = 1'b1;
    start_addr = 7'h20;
    len        = 8'd10;
    m_ready    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("third_beat", m_data, mem[8'h22]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", m_valid, 0);
    chk("abort_last", m_last, 0);
    chk("abort_data", m_data, 0);
    chk("abort_addr", ram_addr, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
      chk("abort_novalid", m_valid, 0);
    end
    @(posedge clk);
    #1;
    run_burst(0, 2, 0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
